// File: rtl/gpio_cmd_master_pkg.sv
// Shared definitions for the GPIO command-protocol initiator:
// command codes, command-word field positions, request payload and FSM states.
package gpio_cmd_master_pkg;

    localparam int unsigned CMD_W      = 8;
    localparam int unsigned PAYLOAD_W  = 23;
    localparam int unsigned WORD_W     = 32;

    localparam int unsigned CMD_MSB    = 31;
    localparam int unsigned CMD_LSB    = 24;
    localparam int unsigned STROBE_BIT = 23;
    localparam int unsigned RD_EN_BIT  = 16;

    localparam logic [CMD_W-1:0] CMD_RST     = 8'h01;
    localparam logic [CMD_W-1:0] CMD_EN_RX   = 8'h02;
    localparam logic [CMD_W-1:0] CMD_SIGMA   = 8'h03;
    localparam logic [CMD_W-1:0] CMD_LOG     = 8'h04;
    localparam logic [CMD_W-1:0] CMD_RAM_RD  = 8'h05;
    localparam logic [CMD_W-1:0] CMD_LOG_BER = 8'h06;
    localparam logic [CMD_W-1:0] CMD_RD_BER  = 8'h07;

    typedef struct packed {
        logic [CMD_W-1:0]     cmd;
        logic [PAYLOAD_W-1:0] data;
        logic                 read;
        logic                 burst;
    } req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SETTLE,
        ST_RESP
    } state_t;

    // Assemble a command word from its three fields.
    function automatic logic [WORD_W-1:0] build_word(
        input logic [CMD_W-1:0]     cmd,
        input logic                 strobe,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [WORD_W-1:0] w;
        w                    = '0;
        w[CMD_MSB:CMD_LSB]   = cmd;
        w[STROBE_BIT]        = strobe;
        w[PAYLOAD_W-1:0]     = payload;
        return w;
    endfunction

endpackage

// File: rtl/gpio_cmd_master_cmd_phase_timer.sv
// Loadable down-counter timing the STROBE and SETTLE phases; done_c is high at zero.
module gpio_cmd_master_cmd_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/gpio_cmd_master.sv
// GPIO command-protocol initiator: sequences setup/strobe/hold phases of the
// command word, captures readback, and runs auto-incrementing RAM dump bursts.
module gpio_cmd_master
    import gpio_cmd_master_pkg::*;
#(
    parameter int unsigned NBT_GPIOS     = 32,
    parameter int unsigned RAM_DEPTH     = 32768,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [7:0]                   i_req_cmd,
    input  logic [22:0]                  i_req_data,
    input  logic                         i_req_read,
    input  logic                         i_req_burst,
    input  logic [$clog2(RAM_DEPTH):0]   i_req_count,
    output logic [NBT_GPIOS-1:0]         o_gpio_to_regf,
    input  logic [NBT_GPIOS-1:0]         i_regf_to_gpio,
    output logic                         o_rsp_valid,
    output logic [NBT_GPIOS-1:0]         o_rsp_data,
    output logic                         o_rsp_last,
    input  logic                         i_rsp_ready,
    output logic                         o_busy
);

    localparam int unsigned AW        = $clog2(RAM_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned MAX_PHASE = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES
                                                                         : SETTLE_CYCLES;
    localparam int unsigned TW        = $clog2(MAX_PHASE) + 1;
    localparam logic [PAYLOAD_W-1:0] ADDR_MASK = PAYLOAD_W'((64'd1 << AW) - 64'd1);

    state_t               state_q, state_n;
    req_t                 req_q, req_n;
    logic [AW-1:0]        addr_q, addr_n, addr_inc;
    logic [CW-1:0]        remain_q, remain_n;
    logic [NBT_GPIOS-1:0] word_q, word_n;
    logic [NBT_GPIOS-1:0] rsp_data_q, rsp_data_n;
    logic                 rsp_last_q, rsp_last_n;
    logic                 rsp_valid_q, req_ready_q, busy_q;
    logic                 timer_load;
    logic [TW-1:0]        timer_value;
    logic                 timer_done_c;

    // Low payload bits carry the burst address; the rest come from the request.
    function automatic logic [PAYLOAD_W-1:0] merge_addr(
        input logic [PAYLOAD_W-1:0] data,
        input logic [AW-1:0]        addr
    );
        return (data & ~ADDR_MASK) | PAYLOAD_W'(addr);
    endfunction

    gpio_cmd_master_cmd_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .i_reset    (i_reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done_c     (timer_done_c)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            word_q      <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            req_q       <= req_n;
            addr_q      <= addr_n;
            remain_q    <= remain_n;
            word_q      <= word_n;
            rsp_data_q  <= rsp_data_n;
            rsp_last_q  <= rsp_last_n;
            rsp_valid_q <= (state_n == ST_RESP);
            req_ready_q <= (state_n == ST_IDLE);
            busy_q      <= (state_n != ST_IDLE);
        end
    end

    always_comb begin
        state_n     = state_q;
        req_n       = req_q;
        addr_n      = addr_q;
        remain_n    = remain_q;
        word_n      = word_q;
        rsp_data_n  = rsp_data_q;
        rsp_last_n  = rsp_last_q;
        timer_load  = 1'b0;
        timer_value = '0;
        addr_inc    = (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    req_n.cmd   = i_req_cmd;
                    req_n.data  = i_req_data;
                    req_n.read  = i_req_read;
                    req_n.burst = i_req_burst && i_req_read && (i_req_cmd == CMD_RAM_RD);
                    addr_n      = i_req_data[AW-1:0];
                    remain_n    = (i_req_count == '0) ? CW'(1) : i_req_count;
                    word_n      = NBT_GPIOS'(build_word(i_req_cmd, 1'b0, i_req_data));
                    state_n     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                word_n[STROBE_BIT] = 1'b1;
                timer_load         = 1'b1;
                timer_value        = TW'(STROBE_CYCLES - 1);
                state_n            = ST_STROBE;
            end
            ST_STROBE: begin
                if (timer_done_c) begin
                    word_n[STROBE_BIT] = 1'b0;
                    state_n            = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (req_q.read) begin
                    timer_load  = 1'b1;
                    timer_value = TW'(SETTLE_CYCLES - 1);
                    state_n     = ST_SETTLE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_done_c) begin
                    rsp_data_n = i_regf_to_gpio;
                    rsp_last_n = !req_q.burst || (remain_q == CW'(1));
                    state_n    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    if (req_q.burst && (remain_q > CW'(1))) begin
                        remain_n = remain_q - CW'(1);
                        addr_n   = addr_inc;
                        word_n   = NBT_GPIOS'(build_word(req_q.cmd, 1'b0,
                                                         merge_addr(req_q.data, addr_inc)));
                        state_n  = ST_SETUP;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_gpio_to_regf = word_q;
    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_last     = rsp_last_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_req_ready    = req_ready_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_gpio_cmd_master.sv
// Scoreboard bench for gpio_cmd_master: directed protocol scenarios plus random
// requests checked against a word/readback model of the register-file protocol.
module tb_gpio_cmd_master;

    localparam int unsigned NBT   = 32;
    localparam int unsigned DEPTH = 32768;
    localparam int unsigned SC    = 2;
    localparam int unsigned TC    = 2;
    localparam int unsigned CW    = 16;

    logic            clk = 1'b0;
    logic            i_reset;
    logic            i_req_valid;
    logic            o_req_ready;
    logic [7:0]      i_req_cmd;
    logic [22:0]     i_req_data;
    logic            i_req_read;
    logic            i_req_burst;
    logic [CW-1:0]   i_req_count;
    logic [NBT-1:0]  o_gpio_to_regf;
    logic [NBT-1:0]  i_regf_to_gpio;
    logic            o_rsp_valid;
    logic [NBT-1:0]  o_rsp_data;
    logic            o_rsp_last;
    logic            i_rsp_ready;
    logic            o_busy;

    gpio_cmd_master #(
        .NBT_GPIOS     (NBT),
        .RAM_DEPTH     (DEPTH),
        .STROBE_CYCLES (SC),
        .SETTLE_CYCLES (TC)
    ) dut (
        .clk            (clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_cmd      (i_req_cmd),
        .i_req_data     (i_req_data),
        .i_req_read     (i_req_read),
        .i_req_burst    (i_req_burst),
        .i_req_count    (i_req_count),
        .o_gpio_to_regf (o_gpio_to_regf),
        .i_regf_to_gpio (i_regf_to_gpio),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_last     (o_rsp_last),
        .i_rsp_ready    (i_rsp_ready),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rsp_t;

    logic [31:0] exp_words[$];
    rsp_t        exp_rsp[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          strobe_rise_cyc = 0;
    int          last_hs_cyc = 0;
    int          n_hs = 0;
    int          n_last = 0;
    bit          hold_ready_low = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_line(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Register-file behaviour: RAM contents and per-command register values.
    function automatic logic [31:0] ram_model(input int unsigned addr);
        return (32'(addr) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] reg_model(input logic [7:0] cmd, input logic [22:0] pl);
        if (cmd == 8'h07) return 32'hDEADBEEF;
        return {cmd, 24'(pl)} ^ 32'h3C3C5A5A;
    endfunction

    function automatic logic [31:0] regf_value(input logic [31:0] word);
        logic [22:0] pl;
        pl = word[22:0];
        if (word[31:24] == 8'h05) return ram_model(int'(pl[14:0]));
        return reg_model(word[31:24], pl);
    endfunction

    // Expected strobed words and responses for one request.
    function automatic void model_push(input logic [7:0] cmd, input logic [22:0] data,
                                       input logic rd, input logic bu, input logic [CW-1:0] cnt);
        bit          is_burst;
        int unsigned n;
        is_burst = bu && rd && (cmd == 8'h05);
        n = is_burst ? ((cnt == 0) ? 1 : int'(cnt)) : 1;
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned addr;
            logic [22:0] pl;
            rsp_t        r;
            addr = (int'(data[14:0]) + k) % DEPTH;
            pl   = is_burst ? {data[22:15], 15'(addr)} : data;
            exp_words.push_back({cmd, 1'b1, pl});
            if (rd) begin
                r.data = (cmd == 8'h05) ? ram_model(addr) : reg_model(cmd, pl);
                r.last = (k == n - 1);
                exp_rsp.push_back(r);
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_req(input logic [7:0] cmd, input logic [22:0] data, input logic rd,
                            input logic bu, input logic [CW-1:0] cnt, output int acc);
        int guard;
        guard       = 0;
        acc         = -1;
        i_req_cmd   = cmd;
        i_req_data  = data;
        i_req_read  = rd;
        i_req_burst = bu;
        i_req_count = cnt;
        i_req_valid = 1'b1;
        model_push(cmd, data, rd, bu, cnt);
        while (!o_req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                fail_line("req_accept_timeout");
                i_req_valid = 1'b0;
                return;
            end
        end
        acc = cyc;
        @(negedge clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(o_req_ready && exp_rsp.size() == 0 && exp_words.size() == 0)) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                fail_line("drain_timeout");
                return;
            end
        end
    endtask

    // Register-file readback: updated the cycle after the strobe is seen.
    always @(negedge clk) begin
        if (!i_reset && o_gpio_to_regf[23]) i_regf_to_gpio = regf_value(o_gpio_to_regf);
    end

    // Response consumer with random backpressure.
    initial begin
        i_rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            i_rsp_ready = hold_ready_low ? 1'b0 : ($urandom_range(0, 9) < 7);
        end
    end

    // Command-word monitor: setup, strobe content/width and hold.
    logic [31:0] prev_word = '0;
    logic        prev_strobe = 1'b0;
    int          strobe_len = 0;
    always @(negedge clk) begin
        if (i_reset) begin
            prev_word   = '0;
            prev_strobe = 1'b0;
            strobe_len  = 0;
        end else begin
            if (o_gpio_to_regf[23] && !prev_strobe) begin
                if (exp_words.size() == 0) fail_line("unexpected_strobe");
                else check("strobe_word", o_gpio_to_regf, exp_words.pop_front());
                check("setup_word", prev_word, o_gpio_to_regf & ~32'h0080_0000);
                strobe_len      = 1;
                strobe_rise_cyc = cyc;
            end else if (o_gpio_to_regf[23]) begin
                strobe_len++;
            end else if (prev_strobe) begin
                check("strobe_len", strobe_len, SC);
                check("hold_word", o_gpio_to_regf, prev_word & ~32'h0080_0000);
            end
            prev_strobe = o_gpio_to_regf[23];
            prev_word   = o_gpio_to_regf;
        end
    end

    // Response monitor: scoreboard pop on handshake, stability under backpressure.
    logic        stalled = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    always @(negedge clk) begin
        if (i_reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("rsp_valid_held", o_rsp_valid, 1'b1);
                check("rsp_data_held", o_rsp_data, held_data);
                check("rsp_last_held", o_rsp_last, held_last);
            end
            if (o_rsp_valid && i_rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    fail_line("unexpected_rsp");
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("rsp_data", o_rsp_data, r.data);
                    check("rsp_last", o_rsp_last, r.last);
                end
                last_hs_cyc = cyc;
                n_hs++;
                if (o_rsp_last) n_last++;
            end
            stalled   = o_rsp_valid && !i_rsp_ready;
            held_data = o_rsp_data;
            held_last = o_rsp_last;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, guard, hs0, last0;
        logic [31:0] saved;
        i_reset        = 1'b1;
        i_req_valid    = 1'b0;
        i_req_cmd      = '0;
        i_req_data     = '0;
        i_req_read     = 1'b0;
        i_req_burst    = 1'b0;
        i_req_count    = '0;
        i_regf_to_gpio = '0;
        repeat (3) @(negedge clk);
        check("reset_word", o_gpio_to_regf, 0);
        check("reset_req_ready", o_req_ready, 1);
        check("reset_rsp_valid", o_rsp_valid, 0);
        check("reset_rsp_data", o_rsp_data, 0);
        check("reset_rsp_last", o_rsp_last, 0);
        check("reset_busy", o_busy, 0);
        i_reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single write
        send_req(8'h03, 23'h00001C, 1'b0, 1'b0, '0, acc);
        check("write_setup_word", o_gpio_to_regf, 32'h0300001C);
        check("write_busy", o_busy, 1);
        repeat (3) @(negedge clk);
        check("write_hold_word", o_gpio_to_regf, 32'h0300001C);
        guard = 0;
        while (!o_req_ready && guard < 50) begin @(negedge clk); guard++; end
        check("write_ready_latency", 64'(cyc - acc), 5);
        check("write_strobe_start", 64'(strobe_rise_cyc - acc), 2);
        check("write_no_rsp", o_rsp_valid, 0);
        wait_idle();

        // Single read
        send_req(8'h07, 23'h010002, 1'b1, 1'b0, '0, acc);
        guard = 0;
        while (!o_rsp_valid && guard < 50) begin @(negedge clk); guard++; end
        check("read_latency", 64'(cyc - acc), 7);
        check("read_data", o_rsp_data, 32'hDEADBEEF);
        check("read_last", o_rsp_last, 1);
        wait_idle();

        // Burst dump with address wrap
        hs0 = n_hs; last0 = n_last;
        send_req(8'h05, 23'h017FFE, 1'b1, 1'b1, CW'(4), acc);
        wait_idle();
        check("burst_rsp_count", 64'(n_hs - hs0), 4);
        check("burst_last_count", 64'(n_last - last0), 1);

        // Backpressure in RESP
        hold_ready_low = 1'b1;
        repeat (2) @(negedge clk);
        send_req(8'h04, 23'h00ABCD, 1'b1, 1'b0, '0, acc);
        guard = 0;
        while (!o_rsp_valid && guard < 50) begin @(negedge clk); guard++; end
        saved = o_rsp_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", o_rsp_valid, 1);
            check("bp_data", o_rsp_data, saved);
            check("bp_req_ready", o_req_ready, 0);
            check("bp_no_strobe", o_gpio_to_regf[23], 0);
        end
        hold_ready_low = 1'b0;
        wait_idle();

        // Second request held while a read is in flight
        send_req(8'h06, 23'h000123, 1'b1, 1'b0, '0, acc);
        send_req(8'h02, 23'h0000AA, 1'b0, 1'b0, '0, acc2);
        check("busy_accept_after_rsp", 64'(acc2), 64'(last_hs_cyc + 1));
        wait_idle();

        // Reset during strobe
        send_req(8'h07, 23'h000055, 1'b1, 1'b0, '0, acc);
        @(negedge clk);
        check("rst_strobe_seen", o_gpio_to_regf[23], 1);
        #1 i_reset = 1'b1;
        #1;
        check("rst_word_async", o_gpio_to_regf, 0);
        check("rst_busy_async", o_busy, 0);
        check("rst_ready_async", o_req_ready, 1);
        exp_rsp.delete();
        exp_words.delete();
        repeat (2) @(negedge clk);
        #1 i_reset = 1'b0;
        hs0 = n_hs;
        repeat (20) @(negedge clk);
        check("rst_no_rsp", 64'(n_hs - hs0), 0);
        check("rst_idle_busy", o_busy, 0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            logic [7:0]    cmd;
            logic [22:0]   data;
            logic [14:0]   low;
            int            r;
            r    = $urandom_range(0, 7);
            cmd  = (r == 0) ? 8'($urandom_range(0, 255))
                 : (r < 4)  ? 8'h05 : 8'($urandom_range(1, 7));
            data = 23'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                low  = 15'h7FFF - 15'($urandom_range(0, 3));
                data = {data[22:15], low};
            end
            send_req(cmd, data, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     CW'($urandom_range(0, 5)), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("final_rsp_queue_empty", exp_rsp.size(), 0);
        check("final_word_queue_empty", exp_words.size(), 0);
        check("final_busy", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_cmd_master.md
Name: gpio_cmd_master

Overview:
Hardware initiator for the GPIO command protocol used by the register file. The word format is: bits [31:24] command, bit 23 strobe, bits [22:0] payload.
- Accepts requests through a valid/ready handshake and drives the command word with the required setup/strobe/hold phases.
- For read-type requests, samples the register-file readback bus and returns it through a response handshake.
- Supports burst RAM dump (command 0x05) with auto-incrementing address.
- Sits between an on-chip controller or debug engine and the register file, replacing the software GPIO driver.

Parameters:
NBT_GPIOS, 32, width of command word and readback bus
RAM_DEPTH, 32768, log RAM depth; address width AW = $clog2(RAM_DEPTH)
STROBE_CYCLES, 2, cycles bit 23 is held high (>=1)
SETTLE_CYCLES, 2, cycles between strobe fall and readback sample (>=1)

Ports:
clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_cmd  in  8  command code (0x01..0x07)
i_req_data  in  23  payload, bits [22:0] of word
i_req_read  in  1  1 = capture readback and produce response
i_req_burst  in  1  1 = burst RAM dump (only honoured with cmd 0x05 and read=1)
i_req_count  in  AW+1  burst length; 0 treated as 1
o_gpio_to_regf  out  NBT_GPIOS  command word to register file
i_regf_to_gpio  in  NBT_GPIOS  readback bus from register file
o_rsp_valid  out  1  response valid
o_rsp_data  out  NBT_GPIOS  captured readback
o_rsp_last  out  1  final response of a request (always 1 for non-burst)
i_rsp_ready  in  1  response consumed when valid&ready
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, immediate): o_gpio_to_regf=0, o_req_ready=1, o_rsp_valid=0, o_rsp_data=0, o_rsp_last=0, o_busy=0, FSM=IDLE.
- Reset mid-operation aborts immediately: strobe drops the same instant and any pending response is discarded.
- FSM states: IDLE, SETUP, STROBE, HOLD, SETTLE, RESP.
- IDLE: o_req_ready=1.
  - On valid&ready, latch cmd/data/read/burst/count into request registers and go to SETUP.
  - In burst, address register = i_req_data[AW-1:0] and remaining = max(count,1).
- SETUP (1 cycle): word = {cmd, 0, payload}. In burst, payload[AW-1:0] is replaced by the current address; all other payload bits come from the latched data.
- STROBE (STROBE_CYCLES cycles): same word with bit 23=1. Payload and cmd are stable for the whole strobe.
- HOLD (1 cycle): bit 23=0, word unchanged.
  - Next state is SETTLE if read=1, else IDLE.
  - o_gpio_to_regf keeps the last word in IDLE; only bit 23 is guaranteed low.
- SETTLE (SETTLE_CYCLES cycles): word unchanged. On the last cycle, register i_regf_to_gpio into o_rsp_data, then go to RESP.
- RESP: o_rsp_valid=1; o_rsp_data and o_rsp_last are stable until i_rsp_ready.
  - On accept: if burst and remaining>1, decrement remaining, address = address+1 mod RAM_DEPTH (wrap RAM_DEPTH-1 -> 0), go to SETUP.
  - Otherwise go to IDLE.
  - o_rsp_last=1 when remaining==1 or not burst.
- Latency, single write: accept at cycle 0, strobe high cycles 2..(1+STROBE_CYCLES), ready again after HOLD.
- Latency, single read: first o_rsp_valid at cycle 3+STROBE_CYCLES+SETTLE_CYCLES after accept.
- i_req_burst with cmd != 0x05 or read=0 is treated as a single transfer.
- Commands outside 0x01..0x07 are issued unchanged; the register file ignores them.
- Requests are never queued: o_req_ready is low outside IDLE.
- A request accepted in the same cycle a response completes is impossible by construction, because responses complete only in RESP.

Decomposition:
- Shared package:
  - command codes: CMD_RST=0x01, CMD_EN_RX=0x02, CMD_SIGMA=0x03, CMD_LOG=0x04, CMD_RAM_RD=0x05, CMD_LOG_BER=0x06, CMD_RD_BER=0x07
  - field positions: CMD_MSB=31, CMD_LSB=24, STROBE_BIT=23, RD_EN_BIT=16
  - FSM state encoding
- One natural sub-module: cmd_phase_timer, a loadable down-counter with a done flag. It is shared by STROBE and SETTLE (load STROBE_CYCLES-1 or SETTLE_CYCLES-1).

Test Plan:
- Single write: cmd 0x03, data 0x00001C, read=0. Required words: SETUP 0x0300001C, STROBE 0x0380001C for 2 cycles, HOLD 0x0300001C. No response; o_req_ready returns to 1.
- Single read: cmd 0x07, data 0x010002, read=1. Bench model drives readback 0xDEADBEEF one cycle after strobe. Required: o_rsp_data=0xDEADBEEF, o_rsp_last=1, valid 7 cycles after accept.
- Burst wrap: cmd 0x05, data 0x017FFE, count 4. Strobed words 0x05817FFE, 0x05817FFF, 0x05810000, 0x05810001. Four responses; o_rsp_last only on the 4th.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP. o_rsp_valid and o_rsp_data stay stable, no new strobe is issued, and o_req_ready stays 0.
- Reset mid-strobe: assert i_reset during STROBE. o_gpio_to_regf=0 immediately (asynchronous), o_busy=0, no response after release.
- Request while busy: i_req_valid held with a second request during a read. It is accepted only after the first response handshake, and its word appears in the following SETUP.
